// File: rtl/muldiv_iter_if.sv
// Handshake and data bundle between the EX stage and the iterative mult/div unit.
// The master side issues operations and reads results; the slave side is the unit itself.
interface muldiv_iter_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [3:0]       op;
    logic             we;
    logic             we_hi;
    logic             rd_hi;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] c;

    modport master (
        output start, op, we, we_hi, rd_hi, a, b,
        input  busy, done, c
    );

    modport slave (
        input  start, op, we, we_hi, rd_hi, a, b,
        output busy, done, c
    );
endinterface

// File: rtl/muldiv_iter.sv
// Iterative radix-2 multiply / restoring divide unit with HI/LO registers.
// Supports MADD/MSUB accumulation, defined divide-by-zero results and abort-on-write.
module muldiv_iter #(
    parameter int WIDTH = 32
) (
    input  logic         clk,
    input  logic         rst,
    muldiv_iter_if.slave bus
);
    localparam int W2    = 2 * WIDTH;
    localparam int CNT_W = $clog2(WIDTH + 1);

    localparam logic [3:0] OP_MUL   = 4'd1;
    localparam logic [3:0] OP_MULU  = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MADD  = 4'd5;
    localparam logic [3:0] OP_MADDU = 4'd6;
    localparam logic [3:0] OP_MSUB  = 4'd7;
    localparam logic [3:0] OP_MSUBU = 4'd8;

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_t;
    typedef enum logic [1:0] {ACC_NONE, ACC_ADD, ACC_SUB} acc_t;

    state_t           state_q;
    acc_t             acc_mode_q;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;
    logic [WIDTH-1:0] ma_q;
    logic [WIDTH-1:0] mb_q;
    logic [WIDTH-1:0] a_raw_q;
    logic [W2-1:0]    work_q;
    logic [W2-1:0]    acc_q;
    logic [CNT_W-1:0] cnt_q;
    logic             neg_res_q;
    logic             neg_rem_q;
    logic             div0_q;
    logic             busy_q;
    logic             done_q;

    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v, input logic is_signed);
        return (is_signed && v[WIDTH-1]) ? -v : v;
    endfunction

    logic op_valid;
    logic op_signed;
    logic op_div;
    acc_t op_acc;

    always_comb begin
        op_valid  = 1'b1;
        op_signed = 1'b0;
        op_div    = 1'b0;
        op_acc    = ACC_NONE;
        case (bus.op)
            OP_MUL:   op_signed = 1'b1;
            OP_MULU:  op_signed = 1'b0;
            OP_DIV:   begin op_signed = 1'b1; op_div = 1'b1; end
            OP_DIVU:  op_div = 1'b1;
            OP_MADD:  begin op_signed = 1'b1; op_acc = ACC_ADD; end
            OP_MADDU: op_acc = ACC_ADD;
            OP_MSUB:  begin op_signed = 1'b1; op_acc = ACC_SUB; end
            OP_MSUBU: op_acc = ACC_SUB;
            default:  op_valid = 1'b0;
        endcase
    end

    logic [WIDTH:0]   mul_sum;
    logic [W2-1:0]    mul_next;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH:0]   div_diff;
    logic [W2-1:0]    div_next;
    logic [W2-1:0]    work_d;
    logic [W2-1:0]    prod_s;
    logic [W2-1:0]    mul_res;
    logic [WIDTH-1:0] quo_s;
    logic [WIDTH-1:0] rem_s;
    logic [W2-1:0]    div_res;
    logic [W2-1:0]    res_d;

    // Multiply: upper half accumulates the multiplicand, multiplier shifts out of the low half.
    // Divide: {remainder, dividend/quotient} shifts left, quotient bits enter at the bottom.
    always_comb begin
        mul_sum   = {1'b0, work_q[W2-1:WIDTH]}
                  + (work_q[0] ? {1'b0, ma_q} : {(WIDTH+1){1'b0}});
        mul_next  = {mul_sum, work_q[WIDTH-1:1]};
        div_shift = {work_q[W2-1:WIDTH], work_q[WIDTH-1]};
        div_diff  = div_shift - {1'b0, mb_q};
        div_next  = div_diff[WIDTH]
                  ? {div_shift[WIDTH-1:0], work_q[WIDTH-2:0], 1'b0}
                  : {div_diff[WIDTH-1:0],  work_q[WIDTH-2:0], 1'b1};
        work_d    = (state_q == S_DIV) ? div_next : mul_next;

        prod_s = neg_res_q ? -mul_next : mul_next;
        case (acc_mode_q)
            ACC_ADD: mul_res = acc_q + prod_s;
            ACC_SUB: mul_res = acc_q - prod_s;
            default: mul_res = prod_s;
        endcase

        // Signed MIN / -1 needs no special case: the magnitude quotient negates back to MIN.
        quo_s   = neg_res_q ? -div_next[WIDTH-1:0]  : div_next[WIDTH-1:0];
        rem_s   = neg_rem_q ? -div_next[W2-1:WIDTH] : div_next[W2-1:WIDTH];
        div_res = div0_q ? {a_raw_q, {WIDTH{1'b1}}} : {rem_s, quo_s};

        res_d = (state_q == S_DIV) ? div_res : mul_res;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            acc_mode_q <= ACC_NONE;
            hi_q       <= '0;
            lo_q       <= '0;
            ma_q       <= '0;
            mb_q       <= '0;
            a_raw_q    <= '0;
            work_q     <= '0;
            acc_q      <= '0;
            cnt_q      <= '0;
            neg_res_q  <= 1'b0;
            neg_rem_q  <= 1'b0;
            div0_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (bus.we) begin
                // A direct write wins over everything and aborts any operation in flight.
                if (bus.we_hi) hi_q <= bus.a;
                else           lo_q <= bus.a;
                state_q <= S_IDLE;
                busy_q  <= 1'b0;
                cnt_q   <= '0;
            end else if (state_q != S_IDLE) begin
                work_q <= work_d;
                cnt_q  <= cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    {hi_q, lo_q} <= res_d;
                    state_q      <= S_IDLE;
                    busy_q       <= 1'b0;
                    done_q       <= 1'b1;
                end
            end else if (bus.start && op_valid) begin
                ma_q       <= mag(bus.a, op_signed);
                mb_q       <= mag(bus.b, op_signed);
                a_raw_q    <= bus.a;
                acc_q      <= {hi_q, lo_q};
                acc_mode_q <= op_acc;
                neg_res_q  <= op_signed & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
                neg_rem_q  <= op_signed & bus.a[WIDTH-1];
                div0_q     <= op_div & (bus.b == '0);
                work_q     <= {{WIDTH{1'b0}}, op_div ? mag(bus.a, op_signed) : mag(bus.b, op_signed)};
                cnt_q      <= CNT_W'(WIDTH);
                state_q    <= op_div ? S_DIV : S_MUL;
                busy_q     <= 1'b1;
            end
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.c    = busy_q ? '0 : (bus.rd_hi ? hi_q : lo_q);
endmodule
